// File: rtl/rv32i_multiplier_arbiter.sv
// Round-robin share of one OP_W x OP_W multiplier IP; IP sees en/operands 1 cycle after a request, requester sees result 1 cycle after IP valid.
// Backpressure: losers hold en until served; grant is held for the whole IP transaction plus one RELEASE cycle.
module rv32i_multiplier_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int OP_W           = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_en,
    input  logic [NUM_REQ*OP_W-1:0] i_req_operand_one,
    input  logic [NUM_REQ*OP_W-1:0] i_req_operand_two,
    output logic [NUM_REQ-1:0]      o_req_valid,
    output logic [2*OP_W-1:0]       o_req_result,
    output logic [NUM_REQ-1:0]      o_req_grant,
    output logic                    o_multiplier_en,
    output logic [OP_W-1:0]         o_multiplier_operand_one,
    output logic [OP_W-1:0]         o_multiplier_operand_two,
    input  logic                    i_multiplier_valid,
    input  logic [2*OP_W-1:0]       i_multiplier_result,
    output logic                    o_err_timeout,
    output logic                    o_err_spurious
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_valid_q, req_valid_d;
    logic               mul_en_q, mul_en_d;
    logic [OP_W-1:0]    op_one_q, op_one_d;
    logic [OP_W-1:0]    op_two_q, op_two_d;
    logic [2*OP_W-1:0]  result_q, result_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_spurious_q, err_spurious_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [SUM_W-1:0]   scan_idx;

    // First requester at or after rr_ptr, wrapping; the extra sum bit handles non-power-of-two NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (scan_idx >= NUM_REQ_S) begin
                scan_idx = scan_idx - NUM_REQ_S;
            end
            if (!win_found && i_req_en[scan_idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        req_valid_d    = '0;
        mul_en_d       = mul_en_q;
        op_one_d       = op_one_q;
        op_two_d       = op_two_q;
        result_d       = result_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;

        case (state_q)
            IDLE: begin
                if (i_multiplier_valid) begin
                    err_spurious_d = 1'b1;
                end
                if (win_found) begin
                    owner_d  = win_idx;
                    grant_d  = NUM_REQ'(1) << win_idx;
                    op_one_d = i_req_operand_one[win_idx*OP_W +: OP_W];
                    op_two_d = i_req_operand_two[win_idx*OP_W +: OP_W];
                    mul_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (i_multiplier_valid) begin
                    // An owner that abandoned keeps the IP transaction but gets no strobe.
                    result_d             = i_multiplier_result;
                    req_valid_d[owner_q] = i_req_en[owner_q];
                    mul_en_d             = 1'b0;
                    state_d              = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    mul_en_d      = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // Requests are not sampled here: the owner's en drop is still in flight.
                if (i_multiplier_valid) begin
                    err_spurious_d = 1'b1;
                end
                grant_d  = '0;
                rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                grant_d  = '0;
                mul_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            grant_q        <= '0;
            req_valid_q    <= '0;
            mul_en_q       <= 1'b0;
            op_one_q       <= '0;
            op_two_q       <= '0;
            result_q       <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            req_valid_q    <= req_valid_d;
            mul_en_q       <= mul_en_d;
            op_one_q       <= op_one_d;
            op_two_q       <= op_two_d;
            result_q       <= result_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign o_req_valid              = req_valid_q;
    assign o_req_result             = result_q;
    assign o_req_grant              = grant_q;
    assign o_multiplier_en          = mul_en_q;
    assign o_multiplier_operand_one = op_one_q;
    assign o_multiplier_operand_two = op_two_q;
    assign o_err_timeout            = err_timeout_q;
    assign o_err_spurious           = err_spurious_q;

    // Invariants: single owner, strobe only to the owner, IP enabled only while BUSY.
    assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(grant_q));
    assert property (@(posedge i_clk) disable iff (!i_rst_n) (req_valid_q & ~grant_q) == '0);
    assert property (@(posedge i_clk) disable iff (!i_rst_n) mul_en_q |-> (state_q == BUSY));

endmodule

// File: tb/tb_rv32i_multiplier_arbiter.sv
// Bench for rv32i_multiplier_arbiter: vector table, hand-written corner sequences, randomized run against a transaction-level model.
module tb_rv32i_multiplier_arbiter;
    localparam int NR = 2;
    localparam int W  = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_en = '0;
    logic [NR*W-1:0] req_op1 = '0;
    logic [NR*W-1:0] req_op2 = '0;
    logic [NR-1:0]   req_valid;
    logic [2*W-1:0]  req_result;
    logic [NR-1:0]   req_grant;
    logic            mul_en;
    logic [W-1:0]    mul_op1;
    logic [W-1:0]    mul_op2;
    logic            mul_valid = 1'b0;
    logic [2*W-1:0]  mul_result = '0;
    logic            err_to;
    logic            err_sp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NR-1:0]  req;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        logic [2*W-1:0] ip_res;
        logic [NR-1:0]  exp_grant;
    } vec_t;
    vec_t vecs[6];

    // Random-phase model state
    int            last_owner, owner, ip_lat, served, exp_w, en_cycles;
    bit            ip_armed, ip_vld_prev;
    logic [NR-1:0] gnt_prev, req_s;
    logic [W-1:0]  ra[NR];
    logic [W-1:0]  rb[NR];
    bit            pend[NR];
    int            idle[NR];
    int            waitc[NR];

    always #5 clk = ~clk;

    rv32i_multiplier_arbiter #(
        .NUM_REQ(NR), .OP_W(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_req_en                 (req_en),
        .i_req_operand_one        (req_op1),
        .i_req_operand_two        (req_op2),
        .o_req_valid              (req_valid),
        .o_req_result             (req_result),
        .o_req_grant              (req_grant),
        .o_multiplier_en          (mul_en),
        .o_multiplier_operand_one (mul_op1),
        .o_multiplier_operand_two (mul_op2),
        .i_multiplier_valid       (mul_valid),
        .i_multiplier_result      (mul_result),
        .o_err_timeout            (err_to),
        .o_err_spurious           (err_sp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op1[r*W +: W] = a;
        req_op2[r*W +: W] = b;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 10 && req_grant == '0; n++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic ip_pulse(input logic [2*W-1:0] res);
        mul_valid  = 1'b1;
        mul_result = res;
        tick();
        mul_valid  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 16'h0003, 16'h0010, 4, 32'h0000_0030, 2'b01};
        vecs[1] = '{2'b10, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001, 2'b10};
        vecs[2] = '{2'b01, 16'h1234, 16'h0002, 2, 32'h0000_2468, 2'b01};
        vecs[3] = '{2'b10, 16'h0000, 16'hABCD, 3, 32'h0000_0000, 2'b10};
        vecs[4] = '{2'b01, 16'h8000, 16'h0002, 6, 32'h0001_0000, 2'b01};
        vecs[5] = '{2'b10, 16'h00FF, 16'h0100, 2, 32'h0000_FF00, 2'b10};

        // Asynchronous reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {req_grant, req_valid, mul_en}, 0);
        check("rst_ops", {mul_op1, mul_op2}, 0);
        check("rst_result", req_result, 0);
        check("rst_err", {err_to, err_sp}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-requester vectors
        for (int v = 0; v < 6; v++) begin
            req_en = vecs[v].req;
            for (int r = 0; r < NR; r++) if (vecs[v].req[r]) set_ops(r, vecs[v].a, vecs[v].b);
            tick();
            check("tbl_grant", req_grant, vecs[v].exp_grant);
            check("tbl_ip_en", mul_en, 1);
            check("tbl_ip_ops", {mul_op1, mul_op2}, {vecs[v].a, vecs[v].b});
            for (int k = 1; k < vecs[v].lat; k++) tick();
            check("tbl_en_held", {mul_en, req_valid}, {1'b1, 2'b00});
            ip_pulse(vecs[v].ip_res);
            check("tbl_valid", req_valid, vecs[v].exp_grant);
            check("tbl_result", req_result, vecs[v].ip_res);
            check("tbl_en_drop", mul_en, 0);
            req_en = '0;
            tick();
            check("tbl_release", {req_grant, req_valid}, 0);
            tick();
        end

        // Contention from reset: alternation 0,1,0,1
        do_reset();
        set_ops(0, 16'd2, 16'd3);
        set_ops(1, 16'd4, 16'd5);
        req_en = 2'b11;
        for (int g = 0; g < 4; g++) begin
            logic [NR-1:0]  exp_g;
            logic [2*W-1:0] exp_r;
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (g % 2 == 0) ? 32'd6 : 32'd20;
            wait_grant();
            check("cont_grant", req_grant, exp_g);
            check("cont_ops", {mul_op1, mul_op2}, (g % 2 == 0) ? 32'h0002_0003 : 32'h0004_0005);
            ip_pulse(exp_r);
            check("cont_valid", req_valid, exp_g);
            check("cont_result", req_result, exp_r);
            req_en = req_en & ~exp_g;
            tick();
            check("cont_release", req_grant, 0);
            req_en = req_en | exp_g;
        end
        req_en = '0;
        tick();
        tick();

        // Operand stability while BUSY
        set_ops(1, 16'd5, 16'd7);
        req_en = 2'b10;
        wait_grant();
        check("stab_grant", req_grant, 2'b10);
        set_ops(1, 16'hFFFF, 16'hFFFF);
        tick();
        tick();
        check("stab_ops", {mul_op1, mul_op2}, 32'h0005_0007);
        ip_pulse(32'd35);
        check("stab_valid", req_valid, 2'b10);
        check("stab_result", req_result, 32'd35);
        req_en = '0;
        tick();
        tick();

        // Abandon: r0 drops en 2 cycles into BUSY, r1 pending
        set_ops(0, 16'd9, 16'd9);
        set_ops(1, 16'd6, 16'd6);
        req_en = 2'b11;
        wait_grant();
        check("abd_grant0", req_grant, 2'b01);
        tick();
        tick();
        req_en = 2'b10;
        tick();
        tick();
        ip_pulse(32'd81);
        check("abd_no_valid", {req_valid, mul_en}, 0);
        tick();
        check("abd_release", req_grant, 0);
        tick();
        check("abd_grant1", {req_grant, mul_en}, 3'b101);
        ip_pulse(32'd36);
        check("abd_valid1", req_valid, 2'b10);
        check("abd_result1", req_result, 32'd36);
        req_en = '0;
        tick();
        tick();

        // Timeout: IP never answers
        set_ops(0, 16'h0011, 16'h0002);
        req_en = 2'b01;
        wait_grant();
        check("to_grant", req_grant, 2'b01);
        en_cycles = int'(mul_en);
        for (int k = 0; k < 7; k++) begin
            tick();
            en_cycles += int'(mul_en);
        end
        check("to_en_cycles", en_cycles, TO);
        tick();
        check("to_abort", {mul_en, req_valid}, 0);
        check("to_flag", err_to, 1);
        tick();
        check("to_release", req_grant, 0);
        tick();
        check("to_regrant", req_grant, 2'b01);
        ip_pulse(32'h22);
        check("to_valid", req_valid, 2'b01);
        check("to_result", req_result, 32'h22);
        check("to_sticky", err_to, 1);
        req_en = '0;
        tick();
        tick();

        // Spurious IP valid in IDLE
        check("sp_clear", err_sp, 0);
        ip_pulse(32'h0);
        check("sp_set", err_sp, 1);
        tick();
        tick();
        check("sp_sticky", err_sp, 1);

        // Reset mid-BUSY while rr_ptr points at r1
        set_ops(0, 16'd1, 16'd1);
        req_en = 2'b01;
        wait_grant();
        check("rstb_grant", req_grant, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        check("rstb_ctrl", {req_grant, req_valid, mul_en}, 0);
        check("rstb_ops", {mul_op1, mul_op2}, 0);
        check("rstb_result", req_result, 0);
        check("rstb_err", {err_to, err_sp}, 0);
        req_en = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ip_pulse(32'h1234);
        check("rstb_late_valid", err_sp, 1);
        set_ops(1, 16'd3, 16'd3);
        req_en = 2'b11;
        wait_grant();
        check("rstb_rr_ptr", req_grant, 2'b01);
        ip_pulse(32'd1);
        check("rstb_valid", req_valid, 2'b01);
        req_en = '0;
        tick();
        tick();

        // Randomized traffic against a transaction-level model
        do_reset();
        last_owner  = NR - 1;
        owner       = 0;
        ip_armed    = 1'b0;
        ip_vld_prev = 1'b0;
        gnt_prev    = '0;
        served      = 0;
        for (int r = 0; r < NR; r++) begin
            pend[r]  = 1'b0;
            idle[r]  = r;
            waitc[r] = 0;
            ra[r]    = '0;
            rb[r]    = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            req_s = req_en;
            if (ip_vld_prev) begin
                check("rnd_valid", req_valid, NR'(1) << owner);
                check("rnd_result", req_result, 32'(ra[owner]) * 32'(rb[owner]));
                check("rnd_en_drop", mul_en, 0);
                check("rnd_wait_bound", waitc[owner] <= 40, 1);
                pend[owner] = 1'b0;
                idle[owner] = $urandom_range(1, 4);
                served++;
            end else begin
                check("rnd_quiet", req_valid, 0);
            end
            if (gnt_prev == '0 && req_grant != '0) begin
                exp_w = -1;
                for (int i = 1; i <= NR; i++) begin
                    if (exp_w < 0 && req_s[(last_owner + i) % NR]) exp_w = (last_owner + i) % NR;
                end
                if (exp_w < 0) begin
                    check("rnd_grant_no_req", req_grant, 0);
                end else begin
                    check("rnd_grant", req_grant, NR'(1) << exp_w);
                    check("rnd_ip_ops", {mul_en, mul_op1, mul_op2}, {1'b1, ra[exp_w], rb[exp_w]});
                    owner      = exp_w;
                    last_owner = exp_w;
                    ip_lat     = $urandom_range(1, 5);
                    ip_armed   = 1'b1;
                end
            end
            gnt_prev    = req_grant;
            ip_vld_prev = 1'b0;
            mul_valid   = 1'b0;
            if (ip_armed) begin
                ip_lat--;
                if (ip_lat == 0) begin
                    mul_valid   = 1'b1;
                    mul_result  = 32'(mul_op1) * 32'(mul_op2);
                    ip_armed    = 1'b0;
                    ip_vld_prev = 1'b1;
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (pend[r]) begin
                    waitc[r]++;
                end else if (idle[r] > 0) begin
                    idle[r]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[r]  = 1'b1;
                    ra[r]    = W'($urandom);
                    rb[r]    = W'($urandom);
                    waitc[r] = 0;
                end
                req_en[r] = pend[r];
                if (pend[r]) set_ops(r, ra[r], rb[r]);
                else         set_ops(r, W'($urandom), W'($urandom));
            end
        end
        mul_valid = 1'b0;
        check("rnd_progress", served >= 150, 1);
        for (int r = 0; r < NR; r++) check("rnd_starve_end", !pend[r] || waitc[r] <= 40, 1);
        check("rnd_errs", {err_to, err_sp}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_multiplier_arbiter.md
Name: rv32I_multiplier_arbiter

Overview:
- Shares the single 16x16 multiplier IP between NUM_REQ execute-stage requesters, such as the shifter control path and the M-extension multiply sequencer.
- Each requester sees the same en/operands/valid/result handshake it would see on the IP directly.
- Round-robin grant; the grant is held for the whole IP transaction.
- Sits between the instruction-execute control paths and the multiplier IP instance.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
OP_W, 16, multiplier operand width; result width is 2*OP_W
TIMEOUT_CYCLES, 64, max cycles granted without i_multiplier_valid before abort

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_req_en  input  NUM_REQ  per-requester request; held high with stable operands until its valid pulse
i_req_operand_one  input  NUM_REQ*OP_W  requester r operand one at bits [r*OP_W +: OP_W]
i_req_operand_two  input  NUM_REQ*OP_W  requester r operand two, same packing
o_req_valid  output  NUM_REQ  one-cycle result strobe, one-hot, to the granted requester
o_req_result  output  2*OP_W  result, shared by all requesters, qualified by o_req_valid
o_req_grant  output  NUM_REQ  one-hot current owner; all zeros when idle
o_multiplier_en  output  1  enable to multiplier IP
o_multiplier_operand_one  output  OP_W  IP operand one
o_multiplier_operand_two  output  OP_W  IP operand two
i_multiplier_valid  input  1  IP result valid
i_multiplier_result  input  2*OP_W  IP result
o_err_timeout  output  1  sticky; set when a transaction aborts on timeout
o_err_spurious  output  1  sticky; set when i_multiplier_valid arrives with no owner

Behaviour:
- Reset (async, i_rst_n=0), all outputs registered:
  - o_multiplier_en=0, o_req_valid=0, o_req_grant=0, operands=0, o_req_result=0, both error flags=0.
  - State=IDLE, rr_ptr=0, timeout counter=0.
  - Reset mid-transaction drops o_multiplier_en immediately; any late IP valid after reset deasserts raises o_err_spurious.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If i_req_en != 0, pick the first set bit searching from rr_ptr upward with wrap-around.
  - At that edge: o_req_grant = winner one-hot, capture the winner's operands into o_multiplier_operand_one/two, o_multiplier_en <= 1, clear the timeout counter, go to BUSY.
  - Latency: request sampled at edge k, so the IP sees en and operands after edge k.
- BUSY:
  - Operands stay frozen at the captured values; later requester operand changes are ignored.
  - The counter increments each cycle.
  - If i_multiplier_valid=1:
    - o_req_result <= i_multiplier_result.
    - o_req_valid[g] <= 1 for one cycle, but only if i_req_en[g] is still high.
    - o_multiplier_en <= 0, go to RELEASE.
    - Result latency to requester: 1 cycle after IP valid.
  - If the owner drops en before valid (abandon): keep the IP transaction running, discard the result (no valid pulse), then go to RELEASE as normal.
  - If the counter reaches TIMEOUT_CYCLES-1 with no valid: o_multiplier_en <= 0, o_err_timeout <= 1, no valid pulse, go to RELEASE.
- RELEASE:
  - Exactly one cycle. o_req_grant <= 0, rr_ptr <= (g+1) mod NUM_REQ, go to IDLE.
  - Requests are not sampled here, because the owner's en deassert is still in flight.
  - Minimum back-to-back spacing is therefore 3 cycles per grant.
- i_multiplier_valid while in IDLE or RELEASE: ignored, o_err_spurious <= 1.
- Simultaneous requests: exactly one winner. The loser waits with en held, and within NUM_REQ grants every holding requester is served (no starvation).
- A requester that deasserts en while not granted is simply never picked; no state is kept.
- Sticky error flags clear only on reset.

Test Plan:
- Single requester: r0 en with ops 0x0003, 0x0010; IP valid after 4 cycles with result 0x00000030 -> o_multiplier_en rises 1 cycle after request; o_req_valid=01 with o_req_result 0x30 one cycle after IP valid; grant returns to 0 after RELEASE.
- Contention: r0 and r1 request in the same cycle from reset -> r0 granted first, r1 second; then both re-request -> r1 wins only if rr_ptr points to it, otherwise r0; verify alternation over 4 grants (0,1,0,1).
- Operand stability: r1 changes operands to 0xFFFF mid-BUSY -> IP operands stay at the captured values; result is routed only to r1.
- Abandon: r0 drops en 2 cycles into BUSY, IP valid at cycle 5 -> no o_req_valid pulse, arbiter goes to RELEASE, then grants pending r1.
- Timeout: TIMEOUT_CYCLES=8, IP never valid -> en drops after 8 granted cycles, o_err_timeout=1 and stays set; next request is still served normally.
- Spurious/reset: pulse i_multiplier_valid in IDLE -> o_err_spurious=1; assert i_rst_n=0 during BUSY -> all outputs 0 immediately, rr_ptr=0.
